// File: rtl/compare_stream_pkg.sv
// Shared types and defaults for the compare-count macro source driver.
package compare_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DrainCyclesDefault = 2;

endpackage

// File: rtl/compare_stream_src_drain_timer.sv
// Loadable down-counter that saturates at zero and flags it.
module compare_stream_src_drain_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/compare_stream_src.sv
// Re-times an upstream ready/valid operand stream into the compare-count macro's
// A/B/VALID/CLR/LOOP protocol and pulses done once the macro counts have settled.
module compare_stream_src
  import compare_stream_pkg::*;
#(
  parameter int unsigned DW           = 64,
  parameter int unsigned CW           = 32,
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [CW-1:0] count_i,
  input  logic [DW-1:0] in_a_i,
  input  logic [DW-1:0] in_b_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic          valid_o,
  output logic          clr_o,
  output logic          loop_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned TimerW = $clog2(DRAIN_CYCLES + 1);

  state_e        state_q;
  logic [CW-1:0] rem_q;
  logic          first_q;
  logic [DW-1:0] a_q, b_q;
  logic          valid_q, clr_q, loop_q, done_q;

  logic accept;
  logic last_accept;
  logic drain_load;
  logic drain_zero;

  assign in_ready_o  = (state_q == StRun) && (rem_q != '0);
  assign accept      = in_ready_o && in_valid_i;
  assign last_accept = accept && (rem_q == CW'(1));

  // The timer loads on the same edge the FSM enters drain, from either path.
  assign drain_load = ((state_q == StIdle) && start_i && (count_i == '0)) ||
                      ((state_q == StRun) && last_accept);

  compare_stream_src_drain_timer #(
    .Width (TimerW)
  ) u_drain_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (drain_load),
    .load_val_i (TimerW'(DRAIN_CYCLES)),
    .dec_i      (state_q == StDrain),
    .zero_o     (drain_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rem_q   <= '0;
      first_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rem_q   <= count_i;
            first_q <= 1'b1;
            loop_q  <= 1'b1;
            state_q <= (count_i != '0) ? StRun : StDrain;
          end
        end
        StRun: begin
          if (accept) begin
            a_q     <= in_a_i;
            b_q     <= in_b_i;
            valid_q <= 1'b1;
            clr_q   <= first_q;
            first_q <= 1'b0;
            rem_q   <= rem_q - CW'(1);
            if (last_accept) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (drain_zero) begin
            state_q <= StDone;
            loop_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign valid_o = valid_q;
  assign clr_o   = clr_q;
  assign loop_o  = loop_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == StRun) || (state_q == StDrain);

endmodule

// File: tb/tb_compare_stream_src.sv
// Randomized bench for compare_stream_src against an event-timeline reference model.
module tb_compare_stream_src;

  localparam int unsigned DW    = 64;
  localparam int unsigned CW    = 32;
  localparam int          Drain = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] count;
  logic [DW-1:0] in_a, in_b;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a, b;
  logic          valid, clr, loop, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] pa[$];
  logic [DW-1:0] pb[$];
  bit            pat[$];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;

  compare_stream_src #(
    .DW           (DW),
    .CW           (CW),
    .DRAIN_CYCLES (Drain)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .count_i    (count),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_o        (a),
    .b_o        (b),
    .valid_o    (valid),
    .clr_o      (clr),
    .loop_o     (loop),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 64'(valid), 64'd0);
    check({tag, " clr"}, 64'(clr), 64'd0);
    check({tag, " loop"}, 64'(loop), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic fill_rand(input int n);
    pa.delete();
    pb.delete();
    for (int i = 0; i < n; i++) begin
      pa.push_back({$urandom, $urandom});
      pb.push_back({$urandom, $urandom});
    end
  endtask

  // Reference: VALID one edge after each accept, DONE Drain+1 edges after the
  // edge that empties the run (or the START edge when count is zero), busy and
  // loop high from the START edge until DONE, ready while pairs are still owed.
  task automatic run(input int cnt, input int pct, input bit use_pat, input bit noise);
    int taken = 0;
    int e = 0;
    int pi = 0;
    int done_at;
    bit first = 1'b1;
    bit fin = 1'b0;
    bit acc, v, exp_valid, exp_clr, exp_busy, exp_rdy;
    exp_valid = 1'b0;
    exp_clr   = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    count    = CW'(cnt);
    in_valid = 1'b0;
    @(posedge clk);
    done_at = (cnt == 0) ? Drain + 1 : -1;
    while (!fin) begin
      @(negedge clk);
      start    = 1'b0;
      exp_busy = (done_at < 0) || (e < done_at);
      exp_rdy  = exp_busy && (taken < cnt);
      check("valid", 64'(valid), 64'(exp_valid));
      check("clr", 64'(clr), 64'(exp_clr));
      check("a", a, exp_a);
      check("b", b, exp_b);
      check("loop", 64'(loop), 64'(exp_busy));
      check("busy", 64'(busy), 64'(exp_busy));
      check("done", 64'(done), 64'(e == done_at));
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (e == done_at) begin
        start    = 1'b1;  // must be ignored while DONE is showing
        count    = CW'(1);
        in_valid = 1'b1;
        fin      = 1'b1;
      end else begin
        v        = use_pat ? ((pi < pat.size()) ? pat[pi] : 1'b1) : ($urandom_range(99) < pct);
        pi++;
        in_valid = v;
        in_a     = (taken < cnt) ? pa[taken] : {$urandom, $urandom};
        in_b     = (taken < cnt) ? pb[taken] : {$urandom, $urandom};
        start    = noise && ($urandom_range(3) == 0);
        count    = CW'($urandom_range(7));
        acc      = exp_rdy && v;
        @(posedge clk);
        e++;
        exp_valid = acc;
        exp_clr   = acc && first;
        if (acc) begin
          exp_a = pa[taken];
          exp_b = pb[taken];
          first = 1'b0;
          taken++;
          if (taken == cnt) done_at = e + Drain + 1;
        end
        if (e > 2000) begin
          check("run timeout", 64'd1, 64'd0);
          fin = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    check_idle("post-done");
    check("post-done a", a, exp_a);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    count    = '0;
    in_a     = '0;
    in_b     = '0;
    in_valid = 1'b0;
    #12;
    check_idle("reset");
    check("reset a", a, 64'd0);
    check("reset b", b, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single element
    pa = '{64'd5};
    pb = '{64'd3};
    run(1, 100, 1'b0, 1'b0);

    // back-to-back
    pa = '{64'd1, 64'd2, 64'd3, 64'd0};
    pb = '{64'd2, 64'd2, 64'd2, 64'd9};
    run(4, 100, 1'b0, 1'b0);

    // bubbles
    fill_rand(3);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run(3, 0, 1'b1, 1'b0);

    // zero count
    run(0, 100, 1'b0, 1'b0);

    // random runs with stray START pulses
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(12);
      fill_rand(n);
      run(n, $urandom_range(100, 30), 1'b0, 1'b1);
    end

    // reset mid-run after two of five accepts
    fill_rand(5);
    @(negedge clk);
    start    = 1'b1;
    count    = CW'(5);
    in_valid = 1'b1;
    in_a     = pa[0];
    in_b     = pb[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_a = pa[1];
    in_b = pb[1];
    @(posedge clk);
    @(negedge clk);
    check("mid-run busy", 64'(busy), 64'd1);
    check("mid-run a", a, pa[1]);
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    check("async reset a", a, 64'd0);
    check("async reset b", b, 64'd0);
    exp_a    = '0;
    exp_b    = '0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_idle("after reset");
    end

    fill_rand(5);
    run(5, 70, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
